// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   XLEN_DEFAULT  : default datapath / PC width
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_t : instruction-fetch handshake states
package riscv_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding for pc
    HOLD  = 2'd1,  // instruction buffered while decode is stalled
    DRAIN = 2'd2   // waiting out a request killed by a redirect
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
//   clk, rst            : clock, asynchronous active-high reset (to bubble)
//   load                : capture next_* as a valid instruction
//   bubble              : insert a NOP bubble (wins over load)
//   next_pc, next_pc_plus4, next_instr : values captured on load
//   pc, pc_plus4, instr, valid         : register contents seen by decode
// With neither load nor bubble the register holds.
module if_id_register
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] next_pc_plus4,
  input  logic [31:0]     next_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     instr,
  output logic            valid
);

  // A bubble is identical to the reset state so decode sees one NOP encoding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (bubble) begin
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (load) begin
      pc       <= next_pc;
      pc_plus4 <= next_pc_plus4;
      instr    <= next_instr;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the instruction-memory handshake and
// the IF/ID register. Tolerates variable-latency memory via a FETCH/HOLD/DRAIN
// FSM and a one-entry hold buffer.
//   clk, rst        : clock, asynchronous active-high reset
//   pc_write_id     : 0 = stall (hold PC and IF/ID)
//   flush_pc        : 1 = IF/ID loads a bubble
//   branch_taken    : MEM-stage redirect, to branch_target (word aligned here)
//   imem_req/addr   : request to instruction memory, stable until ack
//   imem_ack/rdata  : one-cycle acknowledge with data in the same cycle
//   pc_id, pc_plus4_id, instr_id, valid_id : IF/ID register outputs
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write_id,
  input  logic            flush_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic [31:0]     instr_id,
  output logic            valid_id
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] redirect_pc, redirect_pc_next;
  logic [31:0]     buffer, buffer_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            deliver;
  logic [31:0]     deliver_instr;

  // Natural-width add wraps modulo 2^XLEN.
  assign pc_plus4 = pc + XLEN'(4);
  assign target   = {branch_target[XLEN-1:2], 2'b00};

  // In DRAIN pc still holds the killed address, so imem_addr is pc everywhere.
  assign imem_addr = pc;
  assign imem_req  = !rst && (state != HOLD);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; combinational logic below uses blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      redirect_pc <= redirect_pc_next;
    end
  end

  // NOTE: the hold buffer is pure data qualified by the HOLD state, so it has
  // no reset; its contents are never observed before being written.
  always_ff @(posedge clk) begin
    buffer <= buffer_next;
  end

  // NOTE: every output of this block gets a default first so no latch can form.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    redirect_pc_next = redirect_pc;
    buffer_next      = buffer;
    deliver          = 1'b0;
    deliver_instr    = imem_rdata;

    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          if (branch_taken) begin
            pc_next = target;
          end else if (pc_write_id) begin
            deliver = 1'b1;
            pc_next = pc_plus4;
          end else begin
            buffer_next = imem_rdata;
            state_next  = HOLD;
          end
        end else if (branch_taken) begin
          // Request cannot be withdrawn; remember where to go once it returns.
          redirect_pc_next = target;
          state_next       = DRAIN;
        end
      end
      HOLD: begin
        deliver_instr = buffer;
        if (branch_taken) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (pc_write_id) begin
          deliver    = 1'b1;
          pc_next    = pc_plus4;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        // The newest redirect wins, including one arriving with the ack.
        if (branch_taken) begin
          redirect_pc_next = target;
        end
        if (imem_ack) begin
          pc_next    = branch_taken ? target : redirect_pc;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Flush beats stall; otherwise a non-stalled cycle without delivery is a bubble.
  if_id_register #(
    .XLEN(XLEN)
  ) u_if_id (
    .clk           (clk),
    .rst           (rst),
    .load          (deliver),
    .bubble        (flush_pc || (pc_write_id && !deliver)),
    .next_pc       (pc),
    .next_pc_plus4 (pc_plus4),
    .next_instr    (deliver_instr),
    .pc            (pc_id),
    .pc_plus4      (pc_plus4_id),
    .instr         (instr_id),
    .valid         (valid_id)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Memory is either zero-wait (ack = req, data = mem_word(addr)) or driven by hand.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write_id = 1'b1;
  logic        flush_pc = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id, pc_plus4_id, instr_id;
  logic        valid_id;

  logic        auto_mem = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write_id   (pc_write_id),
    .flush_pc      (flush_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_id         (pc_id),
    .pc_plus4_id   (pc_plus4_id),
    .instr_id      (instr_id),
    .valid_id      (valid_id)
  );

  always #5 clk = ~clk;

  // Word at 0x0 is 0x00500093; other addresses flip rd bits, e.g. 0x8 -> 0x00500493.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 7);
  endfunction

  always_comb begin
    if (auto_mem) begin
      imem_ack   = imem_req;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ack   = man_ack;
      imem_rdata = man_rdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic [31:0] ins, input logic v);
    check({tag, ".pc_id"}, pc_id, pc);
    check({tag, ".pc_plus4_id"}, pc_plus4_id, pc4);
    check({tag, ".instr_id"}, instr_id, ins);
    check({tag, ".valid_id"}, {31'b0, valid_id}, {31'b0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst.req", {31'b0, imem_req}, 32'd0);
    check("rst.addr", imem_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, NOP, 1'b0);

    rst = 1'b0;
    #1;
    check("rel.req", {31'b0, imem_req}, 32'd1);
    check("rel.addr", imem_addr, 32'h0);

    // Zero-wait fetch: one instruction per cycle
    tick();
    check_ifid("f0", 32'h0, 32'h4, 32'h0050_0093, 1'b1);
    check("f0.addr", imem_addr, 32'h4);
    tick();
    check_ifid("f4", 32'h4, 32'h8, 32'h0050_0293, 1'b1);
    check("f4.addr", imem_addr, 32'h8);

    // Stall 3 cycles while ack at 0x8 arrives: HOLD, IF/ID unchanged
    pc_write_id = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold.req", {31'b0, imem_req}, 32'd0);
      check("hold.addr", imem_addr, 32'h8);
      check_ifid("hold", 32'h4, 32'h8, 32'h0050_0293, 1'b1);
    end
    pc_write_id = 1'b1;
    tick();
    check_ifid("rel8", 32'h8, 32'hC, 32'h0050_0493, 1'b1);
    check("rel8.addr", imem_addr, 32'hC);
    check("rel8.req", {31'b0, imem_req}, 32'd1);

    // Flush with ack: bubble, pc still advances
    flush_pc = 1'b1;
    tick();
    flush_pc = 1'b0;
    check_ifid("flush", 32'h0, 32'h0, NOP, 1'b0);
    check("flush.addr", imem_addr, 32'h10);

    // Branch with ack in FETCH: rdata discarded, redirect next cycle
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    check_ifid("brack", 32'h0, 32'h0, NOP, 1'b0);
    check("brack.addr", imem_addr, 32'h200);
    tick();
    check_ifid("f200", 32'h200, 32'h204, 32'h0051_0093, 1'b1);
    check("f200.addr", imem_addr, 32'h204);

    // Multi-cycle memory: branch one cycle into the request -> DRAIN
    auto_mem = 1'b0;
    man_ack  = 1'b0;
    tick();
    check("wait.valid", {31'b0, valid_id}, 32'd0);
    check("wait.addr", imem_addr, 32'h204);
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    tick();
    branch_taken = 1'b0;
    check("drain.req", {31'b0, imem_req}, 32'd1);
    check("drain.addr", imem_addr, 32'h204);
    tick();
    check("drain2.addr", imem_addr, 32'h204);
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    check_ifid("drack", 32'h0, 32'h0, NOP, 1'b0);
    check("drack.addr", imem_addr, 32'h100);

    // Redirect overwritten in DRAIN, then wrap at 0xFFFF_FFFC
    branch_taken  = 1'b1;
    branch_target = 32'h500;
    tick();
    check("ovr.addr", imem_addr, 32'h100);
    branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    man_ack      = 1'b1;
    man_rdata    = 32'hCAFE_F00D;
    tick();
    check("ovr.valid", {31'b0, valid_id}, 32'd0);
    check("ovr.target", imem_addr, 32'hFFFF_FFFC);
    man_rdata = 32'h1234_5678;
    tick();
    man_ack = 1'b0;
    check_ifid("wrap", 32'hFFFF_FFFC, 32'h0, 32'h1234_5678, 1'b1);
    check("wrap.addr", imem_addr, 32'h0);

    // Reset mid-request with ack present: ignored, restart at RESET_PC
    man_ack = 1'b1;
    rst     = 1'b1;
    #1;
    check("mrst.req", {31'b0, imem_req}, 32'd0);
    check("mrst.addr", imem_addr, 32'h0);
    tick();
    check_ifid("mrst", 32'h0, 32'h0, NOP, 1'b0);
    man_ack = 1'b0;
    rst     = 1'b0;
    #1;
    check("mrel.req", {31'b0, imem_req}, 32'd1);
    check("mrel.addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V core.
- Owns the PC and the instruction-memory request handshake.
- Drives the IF/ID pipeline register consumed by decode.
- Sits directly downstream of the hazard detection unit and applies its stall (`pc_write_id`) and flush (`flush_pc`) decisions.
- Also applies the MEM-stage branch/jump redirect.
- Tolerates variable-latency instruction memory through a small FSM and a one-entry hold buffer.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- pc_write_id  in  1  from hazard unit; 0 = stall: hold PC and IF/ID
- flush_pc  in  1  from hazard unit; 1 = IF/ID loads a bubble
- branch_taken  in  1  MEM-stage redirect (branch_mux_mem)
- branch_target  in  XLEN  redirect address
- imem_req  out  1  instruction memory request
- imem_addr  out  XLEN  request address, word aligned
- imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction
- pc_id  out  XLEN  IF/ID: PC of instr_id
- pc_plus4_id  out  XLEN  IF/ID: pc_id + 4
- instr_id  out  32  IF/ID: instruction (NOP when bubble)
- valid_id  out  1  IF/ID: instr_id is a real instruction

## Operation
- **FSM states:**
  - FETCH: request outstanding, `imem_req` = 1.
  - HOLD: instruction buffered, `imem_req` = 0.
  - DRAIN: killed request outstanding, `imem_req` = 1.
- **Outputs:**
  - `imem_addr` = pc in FETCH and HOLD; the killed address in DRAIN.
  - `imem_req` and `imem_addr` stay stable until ack. A request is never withdrawn before ack.
- **FETCH:**
  - ack & branch_taken: discard rdata, pc <= {branch_target[XLEN-1:2], 2'b00}, stay in FETCH.
  - ack & pc_write_id: IF/ID <= {pc, pc+4, rdata, valid=1}, pc <= pc+4, stay in FETCH.
  - ack & !pc_write_id: buffer <= rdata, go to HOLD.
  - !ack & branch_taken: redirect_pc <= aligned target, go to DRAIN.
- **DRAIN:**
  - On ack, discard rdata, pc <= redirect_pc, go to FETCH.
  - A further branch_taken in DRAIN overwrites redirect_pc.
- **HOLD:**
  - branch_taken: drop buffer, pc <= aligned target, go to FETCH.
  - pc_write_id: IF/ID <= {pc, pc+4, buffer, valid=1}, pc <= pc+4, go to FETCH.
- **IF/ID update rules (priority high to low):**
  - flush_pc = 1 → IF/ID <= bubble (valid 0, instr 32'h0000_0013), even if pc_write_id = 0. Any instruction delivered that cycle is still consumed and pc still advances; hazard logic owns re-fetch via redirect.
  - pc_write_id = 0 → IF/ID holds.
  - No instruction delivered → bubble.
- **Branch priority:** branch_taken overrides stall; pc redirects even when pc_write_id = 0.
- **PC arithmetic:** pc+4 wraps modulo 2^XLEN; 32'hFFFF_FFFC → 0.

## Timing
- **Reset values:**
  - pc = RESET_PC, state = FETCH.
  - imem_req = 0 while rst is high, 1 in the first cycle after release.
  - imem_addr = RESET_PC.
  - pc_id = 0, pc_plus4_id = 0, instr_id = 32'h0000_0013, valid_id = 0.
- **Reset mid-request:** an in-flight ack is ignored and the FSM restarts at RESET_PC.
- **Throughput:** zero-wait memory (ack in the request cycle) gives 1 instruction/cycle. IF/ID updates at the edge closing the ack cycle.
- **Latency:**
  - branch_taken in cycle N → imem_addr = target in N+1 (FETCH/HOLD), or the cycle after the pending ack (DRAIN).
  - HOLD → FETCH releases on the first edge with pc_write_id = 1.

## Structure
- **Package `riscv_pkg`:**
  - NOP_INSTR = 32'h0000_0013
  - XLEN default
  - fetch_state_t enum {FETCH, HOLD, DRAIN}
- **Sub-module `if_id_register`:** pc, pc_plus4, instr, and valid with load/bubble/hold control; async reset to bubble.
- **Top-level contents:** FSM, PC register, redirect register, hold buffer.

## Test plan
- Reset release, zero-wait memory returning 0x00500093 at 0x0: imem_req rises the cycle after reset; next edge gives pc_id = 0, instr_id = 0x00500093, valid_id = 1; imem_addr = 4.
- Stall with pc_write_id = 0 for 3 cycles during an ack at 0x8: FSM enters HOLD, imem_req = 0, IF/ID unchanged; release delivers the 0x8 instruction, next imem_addr = 0xC.
- 3-cycle-latency memory with branch_taken, target 0x103 asserted one cycle into the request: FSM enters DRAIN; rdata at ack is discarded (valid_id = 0); next imem_addr = 0x100.
- flush_pc = 1 together with ack: IF/ID = NOP with valid_id = 0; pc still advances by 4.
- branch_taken together with ack in FETCH: rdata discarded, imem_addr = target next cycle, no instruction reaches IF/ID.
- PC at 0xFFFF_FFFC with ack: pc_plus4_id = 0 and next imem_addr = 0 (wrap).
